// File: rtl/line_mem_arbiter.sv
// line_mem_arbiter
//   Arbitrates whole-line requests from the icache (read-only) and dcache
//   (read/write) onto a single BEAT_W-wide physical memory port. Each grant
//   becomes a BURST_LEN-beat burst. Read beats are assembled into a shared
//   line buffer, and a one-cycle *_resp pulse is returned to the owner.
//   All outputs are registered.
//
//   Optional feature: define LINE_ARB_RR_EN to alternate icache and dcache
//   when both are pending. Without it, the dcache always has priority.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-low reset
//   i_read/i_addr      icache line read request (level), address
//   i_rdata/i_resp     returned line, completion pulse
//   d_read/d_write     dcache line read / write-back request (level)
//   d_addr/d_wdata     dcache address, write-back line
//   d_rdata/d_resp     returned line, completion pulse
//   pmem_read/write    burst command, held for the whole burst
//   pmem_address       line-aligned burst address
//   pmem_wdata64       current write beat
//   pmem_rdata64       current read beat
//   pmem_resp          one pulse per accepted/valid beat
module line_mem_arbiter #(
    parameter int BEAT_W    = 64,
    parameter int BURST_LEN = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_read,
    input  logic [31:0]                 i_addr,
    output logic [BEAT_W*BURST_LEN-1:0] i_rdata,
    output logic                        i_resp,
    input  logic                        d_read,
    input  logic                        d_write,
    input  logic [31:0]                 d_addr,
    input  logic [BEAT_W*BURST_LEN-1:0] d_wdata,
    output logic [BEAT_W*BURST_LEN-1:0] d_rdata,
    output logic                        d_resp,
    output logic                        pmem_read,
    output logic                        pmem_write,
    output logic [31:0]                 pmem_address,
    output logic [BEAT_W-1:0]           pmem_wdata64,
    input  logic [BEAT_W-1:0]           pmem_rdata64,
    input  logic                        pmem_resp
);
    localparam int LINE_W = BEAT_W * BURST_LEN;
    localparam int BW     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int OFF    = $clog2(LINE_W / 8);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

    typedef enum logic [2:0] {IDLE, IRD, DRD, DWR, DONE} state_e;

    state_e              state_q, state_d;
    logic [BW-1:0]       beat_q, beat_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [31:0]         addr_q, addr_d;
    logic [BEAT_W-1:0]   wdata_q, wdata_d;
    logic                rd_q, rd_d, wr_q, wr_d;
    logic                iresp_q, iresp_d, dresp_q, dresp_d;
    logic                d_win;

    function automatic logic [31:0] align_line(input logic [31:0] a);
        return a & ~((32'd1 << OFF) - 32'd1);
    endfunction

`ifdef LINE_ARB_RR_EN
    // last_d_q: 1 when the most recent grant went to the dcache.
    logic last_d_q, last_d_d;
    assign d_win = (d_read | d_write) & (~i_read | ~last_d_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) last_d_q <= 1'b1;
        else      last_d_q <= last_d_d;
    end

    always_comb begin
        last_d_d = last_d_q;
        if (state_q == IDLE && (d_win || i_read)) last_d_d = d_win;
    end
`else
    assign d_win = d_read | d_write;
`endif

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        line_d  = line_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        iresp_d = 1'b0;
        dresp_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_win) begin
                    addr_d = align_line(d_addr);
                    beat_d = '0;
                    // Write beats read when both are raised.
                    if (d_write) begin
                        state_d = DWR;
                        wr_d    = 1'b1;
                        wdata_d = d_wdata[BEAT_W-1:0];
                    end else begin
                        state_d = DRD;
                        rd_d    = 1'b1;
                    end
                end else if (i_read) begin
                    addr_d  = align_line(i_addr);
                    beat_d  = '0;
                    state_d = IRD;
                    rd_d    = 1'b1;
                end
            end
            IRD, DRD: begin
                if (pmem_resp) begin
                    line_d[int'(beat_q)*BEAT_W +: BEAT_W] = pmem_rdata64;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        rd_d    = 1'b0;
                        state_d = DONE;
                        iresp_d = (state_q == IRD);
                        dresp_d = (state_q == DRD);
                    end
                end
            end
            DWR: begin
                if (pmem_resp) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        wr_d    = 1'b0;
                        state_d = DONE;
                        dresp_d = 1'b1;
                    end else begin
                        // Registered beat data: preload the next beat.
                        wdata_d = d_wdata[int'(beat_d)*BEAT_W +: BEAT_W];
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            line_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            iresp_q <= 1'b0;
            dresp_q <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            iresp_q <= iresp_d;
            dresp_q <= dresp_d;
        end
    end

    assign i_rdata      = line_q;
    assign d_rdata      = line_q;
    assign i_resp       = iresp_q;
    assign d_resp       = dresp_q;
    assign pmem_read    = rd_q;
    assign pmem_write   = wr_q;
    assign pmem_address = addr_q;
    assign pmem_wdata64 = wdata_q;
endmodule

// File: tb/tb_line_mem_arbiter.sv
// Directed bench for line_mem_arbiter (default build: dcache over icache).
module tb_line_mem_arbiter;
    logic         clk = 1'b0;
    logic         rst;
    logic         i_read, d_read, d_write, pmem_resp;
    logic [31:0]  i_addr, d_addr;
    logic [255:0] d_wdata;
    logic [63:0]  pmem_rdata64;
    logic [255:0] i_rdata, d_rdata;
    logic         i_resp, d_resp, pmem_read, pmem_write;
    logic [31:0]  pmem_address;
    logic [63:0]  pmem_wdata64;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0;

    line_mem_arbiter #(.BEAT_W(64), .BURST_LEN(4)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata64(pmem_wdata64), .pmem_rdata64(pmem_rdata64), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Plays memory beats first..last with `waits` idle cycles before each,
    // checking that command and address stay put for the whole burst.
    task automatic run_beats(input logic [255:0] rl, input logic [255:0] wl, input logic wr,
                             input logic [31:0] a, input int waits, input int first,
                             input int last);
        for (int b = first; b <= last; b++) begin
            for (int w = 0; w < waits; w++) begin
                pmem_resp = 1'b0;
                step();
                chk("hold_cmd", 256'({pmem_write, pmem_read}), 256'({wr, ~wr}));
                chk("hold_addr", 256'(pmem_address), 256'(a));
            end
            if (wr) chk("wbeat", 256'(pmem_wdata64), 256'(wl[b*64 +: 64]));
            pmem_rdata64 = rl[b*64 +: 64];
            pmem_resp    = 1'b1;
            step();
            pmem_resp = 1'b0;
            if (b < 3) begin
                chk("burst_cmd", 256'({pmem_write, pmem_read}), 256'({wr, ~wr}));
                chk("burst_addr", 256'(pmem_address), 256'(a));
            end
        end
    endtask

    logic [255:0] L1, L2, L3, L4, L5, W, Z;

    initial begin
        L1 = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        W  = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
        L2 = {64'h2222_0000_0000_0004, 64'h2222_0000_0000_0003,
              64'h2222_0000_0000_0002, 64'h2222_0000_0000_0001};
        L3 = {64'h3333_0000_0000_0004, 64'h3333_0000_0000_0003,
              64'h3333_0000_0000_0002, 64'h3333_0000_0000_0001};
        L4 = {64'h4444_4444_0000_0004, 64'h4444_4444_0000_0003,
              64'h4444_4444_0000_0002, 64'h4444_4444_0000_0001};
        L5 = {64'h5555_0000_5555_0004, 64'h5555_0000_5555_0003,
              64'h5555_0000_5555_0002, 64'h5555_0000_5555_0001};
        Z  = '0;
        rst = 1'b0; i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; pmem_rdata64 = '0;

        // Reset values
        #12;
        chk("rst_i_resp", 256'(i_resp), 256'(0));
        chk("rst_d_resp", 256'(d_resp), 256'(0));
        chk("rst_pread", 256'(pmem_read), 256'(0));
        chk("rst_pwrite", 256'(pmem_write), 256'(0));
        chk("rst_paddr", 256'(pmem_address), 256'(0));
        chk("rst_pwdata", 256'(pmem_wdata64), 256'(0));
        chk("rst_i_rdata", i_rdata, Z);
        chk("rst_d_rdata", d_rdata, Z);
        step();
        rst = 1'b1;

        // Icache read, zero-wait memory
        step();
        i_read = 1'b1; i_addr = 32'h0000_0064; t0 = cyc;
        step();
        chk("ird_cmd", 256'({pmem_write, pmem_read}), 256'(2'b01));
        chk("ird_addr", 256'(pmem_address), 256'(32'h60));
        run_beats(L1, Z, 1'b0, 32'h60, 0, 0, 3);
        chk("ird_done_cmd", 256'(pmem_read), 256'(0));
        chk("ird_resp", 256'({i_resp, d_resp}), 256'(2'b10));
        chk("ird_data", i_rdata, L1);
        // request visible in cycle 1, resp visible in cycle 6 (5 edges later)
        chk("ird_latency", 256'(cyc - t0), 256'(5));
        i_read = 1'b0;
        step();
        chk("ird_pulse", 256'(i_resp), 256'(0));
        chk("shared_buf", d_rdata, L1);

        // Dcache write-back
        d_write = 1'b1; d_addr = 32'h0000_0100; d_wdata = W;
        step();
        chk("dwr_cmd", 256'({pmem_write, pmem_read}), 256'(2'b10));
        chk("dwr_addr", 256'(pmem_address), 256'(32'h100));
        run_beats(Z, W, 1'b1, 32'h100, 0, 0, 3);
        chk("dwr_done_cmd", 256'(pmem_write), 256'(0));
        chk("dwr_resp", 256'({i_resp, d_resp}), 256'(2'b01));
        chk("dwr_buf_kept", i_rdata, L1);
        d_write = 1'b0;
        step();
        chk("dwr_pulse", 256'(d_resp), 256'(0));

        // Simultaneous d_read and i_read: dcache first, then icache (3 waits)
        d_read = 1'b1; d_addr = 32'h0000_1234;
        i_read = 1'b1; i_addr = 32'h0000_0ABC;
        step();
        chk("both_first_addr", 256'(pmem_address), 256'(32'h1220));
        run_beats(L2, Z, 1'b0, 32'h1220, 0, 0, 3);
        chk("both_d_resp", 256'({i_resp, d_resp}), 256'(2'b01));
        chk("both_d_data", d_rdata, L2);
        d_read = 1'b0;
        step();
        chk("done_no_grant", 256'({d_resp, pmem_read}), 256'(0));
        step();
        chk("both_second_cmd", 256'(pmem_read), 256'(1));
        chk("both_second_addr", 256'(pmem_address), 256'(32'hAA0));
        run_beats(L3, Z, 1'b0, 32'hAA0, 3, 0, 3);
        chk("wait_i_resp", 256'({i_resp, d_resp}), 256'(2'b10));
        chk("wait_data", i_rdata, L3);
        i_read = 1'b0;
        step();

        // Reset after beat 2 of a read
        i_read = 1'b1; i_addr = 32'h0000_0040;
        step();
        run_beats(L4, Z, 1'b0, 32'h40, 0, 0, 2);
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_pread", 256'(pmem_read), 256'(0));
        chk("rst_mid_resp", 256'(i_resp), 256'(0));
        chk("rst_mid_buf", i_rdata, Z);
        i_read = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("rst_mid_no_resp", 256'({i_resp, pmem_read}), 256'(0));
        i_read = 1'b1; i_addr = 32'h0000_0080;
        step();
        chk("post_rst_addr", 256'(pmem_address), 256'(32'h80));
        run_beats(L4, Z, 1'b0, 32'h80, 0, 0, 3);
        chk("post_rst_resp", 256'(i_resp), 256'(1));
        chk("post_rst_data", i_rdata, L4);
        i_read = 1'b0;
        step();

        // i_read dropped after beat 1: burst still completes
        i_read = 1'b1; i_addr = 32'h0000_00C8;
        step();
        run_beats(L5, Z, 1'b0, 32'hC0, 0, 0, 1);
        i_read = 1'b0;
        run_beats(L5, Z, 1'b0, 32'hC0, 1, 2, 3);
        chk("drop_resp", 256'(i_resp), 256'(1));
        chk("drop_data", i_rdata, L5);
        step();
        chk("drop_pulse", 256'(i_resp), 256'(0));
        step();
        chk("drop_idle", 256'({i_resp, pmem_read, pmem_write}), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/line_mem_arbiter.md
# line_mem_arbiter

Sits between the split L1 caches and the 64-bit physical memory port of the `mp3` top. Arbitrates whole-line (256-bit) requests from the icache (read-only) and dcache (read/write). Serializes each granted request into a 4-beat, 64-bit burst on the `pmem_*` interface and returns the assembled line with a single-cycle response pulse. All outputs are registered.

## Interface
- `BEAT_W`, 64: width of one pmem beat.
- `BURST_LEN`, 4: beats per line; line width is `BEAT_W*BURST_LEN` (256).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `i_read` in 1: icache line read request, level, held until `i_resp`.
- `i_addr` in 32: icache request address.
- `i_rdata` out 256: returned line.
- `i_resp` out 1: one-cycle completion pulse.
- `d_read` in 1: dcache line read request.
- `d_write` in 1: dcache line write-back request.
- `d_addr` in 32: dcache request address.
- `d_wdata` in 256: write-back line, stable while `d_write` is high.
- `d_rdata` out 256: returned line.
- `d_resp` out 1: one-cycle completion pulse.
- `pmem_read` out 1: burst read, held for the whole burst.
- `pmem_write` out 1: burst write, held for the whole burst.
- `pmem_address` out 32: `{addr[31:5],5'b0}`, constant for the whole burst.
- `pmem_wdata64` out 64: current write beat.
- `pmem_rdata64` in 64: current read beat.
- `pmem_resp` in 1: beat accepted or valid, one pulse per beat.

## Operation
- States: IDLE, IRD, DRD, DWR, DONE.
- IDLE arbitration:
  - If any dcache request is pending, grant the dcache. `d_write` has priority over `d_read` if both are high (illegal input, defined behaviour).
  - Otherwise, if `i_read` is high, grant the icache.
  - Otherwise, stay in IDLE.
- On grant:
  - Latch the owner and the aligned address.
  - Clear the beat counter `beat` (2 bits).
  - Next state is IRD, DRD or DWR. `pmem_read` or `pmem_write` rises in the same edge.
- Read states: on each `pmem_resp`, store `pmem_rdata64` into line bits `[64*beat +: 64]`, then increment `beat`.
- Write state: `pmem_wdata64 = d_wdata[64*beat +: 64]`. Advance `beat` on each `pmem_resp`.
- Burst end: a `pmem_resp` while `beat==3` clears `pmem_read`/`pmem_write` and moves to DONE.
- DONE:
  - Pulse the owner's `*_resp` for exactly one cycle.
  - Return to IDLE. Requests seen during DONE are not arbitrated.
- `i_rdata` and `d_rdata` both present the shared line buffer. The buffer holds its value until the next read burst writes it.
- Requester deassertion mid-burst is ignored: the burst completes and `resp` still pulses.
- `pmem_resp` in IDLE or DONE is ignored.

## Timing
- Reset values:
  - State: IDLE.
  - `beat`: 0.
  - Line buffer, `i_rdata`, `d_rdata`: 0.
  - `i_resp`, `d_resp`, `pmem_read`, `pmem_write`: 0.
  - `pmem_address`, `pmem_wdata64`: 0.
  - Round-robin pointer: dcache.
- Reset mid-burst: outputs clear asynchronously and the burst is abandoned. No `resp` is issued.
- Latency:
  - Request at edge N gives pmem command high after edge N+1.
  - With memory beats at cycles k0..k3, `resp` is high in the cycle after the k3 edge.
  - Minimum (zero-wait memory): 6 cycles from request to `resp`.
- The requester must drop its request in the cycle after `resp`. Minimum spacing between two grants is 2 cycles (DONE, IDLE).
- `pmem_address` and command change only on state transitions, never mid-burst.

## Configuration
- `LINE_ARB_RR_EN` defined:
  - Round-robin arbitration between icache and dcache.
  - After a burst for one owner, the other owner wins if both are pending.
  - Within the dcache, write still beats read.
- `LINE_ARB_RR_EN` undefined: fixed dcache-over-icache priority as described in Operation; no pointer register.

## Test plan
- Icache read, addr `0x0000_0064`, memory returns beats `0x11..11`, `0x22..22`, `0x33..33`, `0x44..44` with zero wait:
  - `pmem_address=0x60`.
  - `i_rdata={44..,33..,22..,11..}`.
  - `i_resp` high for one cycle, 6 cycles after request.
- Dcache write, `d_wdata=0xDDDD..._CCCC..._BBBB..._AAAA...`, addr `0x100`: beats on `pmem_wdata64` appear in order AAAA, BBBB, CCCC, DDDD; `d_resp` pulses once.
- `i_read` and `d_read` asserted in the same cycle:
  - Without macro: dcache is served first, then icache.
  - With `LINE_ARB_RR_EN` and the previous owner dcache: icache is served first.
- Memory inserts 3 wait cycles before each beat: `pmem_read` and `pmem_address` stay constant for all 16 cycles; data is assembled correctly.
- `rst` pulled low after beat 2 of a read: `pmem_read` drops immediately and no `resp` is issued. After release, a new `i_read` completes normally.
- `i_read` deasserted after beat 1: the burst still completes and `i_resp` pulses once; the arbiter then returns to IDLE.
